// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs {huffman code, amplitude bits} symbols MSB-first into a
// 32-bit accumulator and emits whole bytes on a valid/ready byte interface.
// A flush pads the last partial byte with 1s and drains the accumulator.
// Optional macro JPEG_BYTE_STUFF_EN: insert 0x00 after every emitted 0xFF.
module jpeg_bit_packer (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_en,
   input  logic        I_code_valid,
   input  logic [4:0]  I_huff_len,
   input  logic [15:0] I_huff_code,
   input  logic [2:0]  I_amp_size,
   input  logic [7:0]  I_amp_code,
   input  logic        I_flush,
   output logic        O_in_ready,
   output logic [7:0]  O_byte,
   output logic        O_byte_valid,
   input  logic        I_byte_ready,
   output logic        O_flush_done
);

   typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;

   state_t      state;
   logic [31:0] acc;
   logic [5:0]  fill;

   logic        out_free;
   logic        pop;
   logic        accept;
   logic        flush_req;
   logic        drain_done;
   logic        stuff_load;
   logic [15:0] huff_mask;
   logic [7:0]  amp_mask;
   logic [4:0]  sym_len;
   logic [22:0] sym_bits;
   logic [31:0] acc_base;
   logic [31:0] acc_next;
   logic [31:0] pad_mask;
   logic [5:0]  fill_base;
   logic [5:0]  fill_round;
   logic [5:0]  fill_next;
   logic [5:0]  shamt;

   assign O_in_ready = (state == RUN) && (fill <= 6'd8);

`ifdef JPEG_BYTE_STUFF_EN
   logic stuff_pending;

   // remember a popped 0xFF until its 0x00 stuff byte has been loaded
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         stuff_pending <= 1'b0;
      end else if (I_en) begin
         if (stuff_load)
            stuff_pending <= 1'b0;
         else if (pop && (acc[31:24] == 8'hFF))
            stuff_pending <= 1'b1;
      end
   end

   assign stuff_load = out_free && stuff_pending;
`else
   logic stuff_pending;

   assign stuff_pending = 1'b0;
   assign stuff_load    = 1'b0;
`endif

   // next accumulator/fill: pop first, then append the symbol or the padding
   always_comb begin
      out_free   = !O_byte_valid || I_byte_ready;
      pop        = out_free && (fill >= 6'd8) && !stuff_pending;
      accept     = I_code_valid && O_in_ready;
      flush_req  = I_flush && O_in_ready;
      huff_mask  = ~(16'hFFFF << I_huff_len);
      amp_mask   = ~(8'hFF << I_amp_size);
      sym_len    = I_huff_len + {2'b00, I_amp_size};
      sym_bits   = ({7'b0, I_huff_code & huff_mask} << I_amp_size)
                   | {15'b0, I_amp_code & amp_mask};
      acc_base   = pop ? {acc[23:0], 8'h00} : acc;
      fill_base  = pop ? (fill - 6'd8) : fill;
      // symbol lands right after the valid bits left once this cycle's pop is taken
      shamt      = 6'd32 - fill_base - {1'b0, sym_len};
      fill_round = (fill_base + 6'd7) & 6'b111000;
      // a shift by 32 yields zero, so an aligned fill gives an empty pad mask
      pad_mask   = (32'hFFFF_FFFF >> fill_base) & ~(32'hFFFF_FFFF >> fill_round);
      acc_next   = acc_base;
      fill_next  = fill_base;
      drain_done = 1'b0;
      case (state)
         RUN: begin
            if (accept) begin
               acc_next  = acc_base | ({9'b0, sym_bits} << shamt);
               fill_next = fill_base + {1'b0, sym_len};
            end
         end
         PAD: begin
            acc_next  = acc_base | pad_mask;
            fill_next = fill_round;
         end
         DRAIN: begin
            drain_done = (fill == 6'd0) && !stuff_pending && out_free;
         end
         default: ;
      endcase
   end

   // accumulator, output byte register and flush state machine
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state        <= RUN;
         acc          <= '0;
         fill         <= '0;
         O_byte       <= '0;
         O_byte_valid <= 1'b0;
         O_flush_done <= 1'b0;
      end else if (I_en) begin
         acc          <= acc_next;
         fill         <= fill_next;
         O_flush_done <= drain_done;
         if (stuff_load) begin
            O_byte       <= 8'h00;
            O_byte_valid <= 1'b1;
         end else if (pop) begin
            O_byte       <= acc[31:24];
            O_byte_valid <= 1'b1;
         end else if (I_byte_ready) begin
            O_byte_valid <= 1'b0;
         end
         case (state)
            RUN:     if (flush_req) state <= PAD;
            PAD:     state <= DRAIN;
            DRAIN:   if (drain_done) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Bench for jpeg_bit_packer: directed and random symbol streams checked against
// a bit-queue reference model (append bits, pad with 1s, slice bytes, stuff 0x00).
module tb_jpeg_bit_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        code_valid;
   logic [4:0]  huff_len;
   logic [15:0] huff_code;
   logic [2:0]  amp_size;
   logic [7:0]  amp_code;
   logic        flush;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        byte_valid;
   logic        byte_ready;
   logic        flush_done;

   int          n_assert = 0;
   int          n_fail   = 0;
   bit          ebits[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [7:0]  want_q[$];
   int          bits_in;
   int          hs_count;
   logic        hold_prev = 1'b0;
   logic [7:0]  hold_byte;
   logic        accepted_now;
   logic        rand_mode = 1'b0;

`ifdef JPEG_BYTE_STUFF_EN
   localparam bit STUFF = 1'b1;
`else
   localparam bit STUFF = 1'b0;
`endif

   jpeg_bit_packer dut (
      .I_clk        (clk),
      .I_rst        (rst),
      .I_en         (en),
      .I_code_valid (code_valid),
      .I_huff_len   (huff_len),
      .I_huff_code  (huff_code),
      .I_amp_size   (amp_size),
      .I_amp_code   (amp_code),
      .I_flush      (flush),
      .O_in_ready   (in_ready),
      .O_byte       (out_byte),
      .O_byte_valid (byte_valid),
      .I_byte_ready (byte_ready),
      .O_flush_done (flush_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pack_bytes();
      while (ebits.size() >= 8) begin
         logic [7:0] b;
         b = '0;
         for (int i = 0; i < 8; i++) b = {b[6:0], ebits.pop_front()};
         exp_q.push_back(b);
         if (STUFF && b == 8'hFF) exp_q.push_back(8'h00);
      end
   endtask

   task automatic model_append(input logic [4:0] l, input logic [15:0] c,
                               input logic [2:0] s, input logic [7:0] a);
      for (int i = int'(l) - 1; i >= 0; i--) ebits.push_back(c[i]);
      for (int i = int'(s) - 1; i >= 0; i--) ebits.push_back(a[i]);
      bits_in += int'(l) + int'(s);
      pack_bytes();
   endtask

   task automatic model_flush();
      while (ebits.size() % 8 != 0) ebits.push_back(1'b1);
      pack_bytes();
   endtask

   // one clock: check at the negedge, update the model, step to the next negedge
   task automatic cycle();
      logic [7:0] s_byte;
      logic       s_valid, s_ready, s_done, e_snap;
      logic [7:0] e;
      if (rand_mode) begin
         en         = ($urandom % 8) != 0;
         byte_ready = ($urandom % 4) != 0;
      end
      accepted_now = 1'b0;
      if (hold_prev) begin
         chk("hold_byte", out_byte, hold_byte);
         chk("hold_valid", byte_valid, 1'b1);
      end
      if (!byte_ready && hs_count == 0 && bits_in > 16)
         chk("in_ready_backpressure", in_ready, 1'b0);
      if (en && in_ready && (code_valid || flush)) accepted_now = 1'b1;
      if (en && code_valid && in_ready) model_append(huff_len, huff_code, amp_size, amp_code);
      if (en && flush && in_ready) model_flush();
      if (en && byte_valid && byte_ready) begin
         hs_count++;
         got_q.push_back(out_byte);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk("byte_stream", out_byte, e);
      end
      hold_prev = byte_valid && !(en && byte_ready);
      hold_byte = out_byte;
      s_byte  = out_byte;
      s_valid = byte_valid;
      s_ready = in_ready;
      s_done  = flush_done;
      e_snap  = en;
      @(posedge clk);
      @(negedge clk);
      if (!e_snap) begin
         chk("freeze_byte", out_byte, s_byte);
         chk("freeze_valid", byte_valid, s_valid);
         chk("freeze_in_ready", in_ready, s_ready);
         chk("freeze_flush_done", flush_done, s_done);
      end
   endtask

   task automatic send(input logic [4:0] l, input logic [15:0] c, input logic [2:0] s,
                       input logic [7:0] a, input logic v, input logic f);
      int budget;
      huff_len   = l;
      huff_code  = c;
      amp_size   = s;
      amp_code   = a;
      code_valid = v;
      flush      = f;
      budget     = 0;
      do begin
         cycle();
         budget++;
      end while (!accepted_now && budget < 300);
      chk("send_accepted", accepted_now, 1'b1);
      code_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen       = 1'b0;
      rand_mode  = 1'b0;
      en         = 1'b1;
      byte_ready = 1'b1;
      for (int k = 0; k < 400 && !seen; k++) begin
         cycle();
         seen = flush_done;
      end
      chk({tag, "_flush_done"}, seen, 1'b1);
      chk({tag, "_all_bytes"}, exp_q.size(), 0);
      cycle();
      chk({tag, "_done_pulse"}, flush_done, 1'b0);
   endtask

   task automatic start_test();
      got_q.delete();
      want_q.delete();
      bits_in  = 0;
      hs_count = 0;
   endtask

   task automatic expect_bytes(input string tag);
      chk({tag, "_count"}, got_q.size(), want_q.size());
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         chk({tag, "_byte"}, got_q[i], want_q[i]);
   endtask

   initial begin
      int k, cyc;
      logic [15:0] bp_code[10];
      logic [7:0]  bp_amp[10];

      rst = 1'b1; en = 1'b1; code_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
      huff_len = '0; huff_code = '0; amp_size = '0; amp_code = '0;
      bits_in = 0; hs_count = 0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_valid", byte_valid, 1'b0);
      chk("reset_byte", out_byte, 8'h00);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_flush_done", flush_done, 1'b0);
      rst = 1'b0;
      cycle();

      // packing: 1010 + 0011 -> 0xA3
      start_test();
      send(5'd4, 16'h000A, 3'd4, 8'h03, 1'b1, 1'b0);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      wait_done("pack");
      want_q.push_back(8'hA3);
      expect_bytes("pack");

      // padding: 010 + five 1s -> 0x5F (garbage above len/size ignored)
      start_test();
      send(5'd3, 16'hFFFA, 3'd0, 8'hFF, 1'b1, 1'b0);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      wait_done("pad");
      want_q.push_back(8'h5F);
      expect_bytes("pad");

      // stuffing
      start_test();
      send(5'd8, 16'h00FF, 3'd0, 8'h00, 1'b1, 1'b0);
      send(5'd8, 16'h0012, 3'd0, 8'h00, 1'b1, 1'b0);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      wait_done("stuff");
      want_q.push_back(8'hFF);
`ifdef JPEG_BYTE_STUFF_EN
      want_q.push_back(8'h00);
`endif
      want_q.push_back(8'h12);
      expect_bytes("stuff");

      // symbol and flush in the same cycle: 11111 + 111 -> 0xFF
      start_test();
      send(5'd5, 16'h001F, 3'd0, 8'h00, 1'b1, 1'b1);
      wait_done("simul");
      want_q.push_back(8'hFF);
`ifdef JPEG_BYTE_STUFF_EN
      want_q.push_back(8'h00);
`endif
      expect_bytes("simul");

      // backpressure: ten 23-bit symbols, downstream stalled for 20 cycles
      start_test();
      for (int i = 0; i < 10; i++) begin
         bp_code[i] = 16'($urandom);
         bp_amp[i]  = 8'($urandom);
      end
      byte_ready = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < 10 && cyc < 600) begin
         huff_len   = 5'd16;
         huff_code  = bp_code[k];
         amp_size   = 3'd7;
         amp_code   = bp_amp[k];
         code_valid = 1'b1;
         cycle();
         if (accepted_now) k++;
         cyc++;
         if (cyc == 20) begin
            chk("bp_stalled_after_one", k, 1);
            chk("bp_valid_held", byte_valid, 1'b1);
            byte_ready = 1'b1;
         end
      end
      code_valid = 1'b0;
      chk("bp_all_sent", k, 10);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      wait_done("bp");

      // random stream with random enable and downstream ready
      start_test();
      rand_mode = 1'b1;
      for (int i = 0; i < 60; i++)
         send(5'($urandom_range(0, 16)), 16'($urandom), 3'($urandom_range(0, 7)),
              8'($urandom), 1'b1, 1'b0);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      wait_done("rand");

      // reset in the middle of a drain
      start_test();
      byte_ready = 1'b0;
      send(5'd16, 16'hBEEF, 3'd0, 8'h00, 1'b1, 1'b0);
      send(5'd0, 16'h0000, 3'd0, 8'h00, 1'b0, 1'b1);
      cycle();
      cycle();
      cycle();
      chk("pre_reset_valid", byte_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", byte_valid, 1'b0);
      chk("midrst_byte", out_byte, 8'h00);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_flush_done", flush_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      ebits.delete();
      exp_q.delete();
      hold_prev  = 1'b0;
      byte_ready = 1'b1;
      cycle();
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_valid", byte_valid, 1'b0);

      // recovery after reset
      start_test();
      send(5'd4, 16'h000A, 3'd4, 8'h03, 1'b1, 1'b1);
      wait_done("recover");
      want_q.push_back(8'hA3);
      expect_bytes("recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
